id_ex_stage_reg: RTL and testbench
==================================

Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register of the 5-stage 64-bit core.
- Captures decoded operands, register numbers and control from decode, and presents them to the EX-stage forwarding unit and ALU.
- Detects load-use hazards: stalls fetch/decode one cycle and inserts a bubble.
- Closes the WB→ID bypass gap that the EX/MEM forwarding paths do not cover.
- Handles branch flush and downstream hold; keeps saturating stall/bubble counters.

Parameters:
DATA_W, 64, operand/immediate width
REG_W, 5, register-number width
ZERO_REG, 31, hard-wired zero register number (XZR)
CNT_W, 16, width of performance counters

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
id_valid  in  1  decode stage holds a real instruction
id_rd1  in  DATA_W  register-file read data for rn
id_rd2  in  DATA_W  register-file read data for rm
id_imm  in  DATA_W  sign-extended immediate
id_rn  in  REG_W  source register A
id_rm  in  REG_W  source register B
id_rd  in  REG_W  destination register
id_uses_rm  in  1  instruction reads rm
id_ctrl  in  9  {aluOp[3:0], aluSrc, memRead, memWrite, regWrite, memToReg}
wb_regWrite  in  1  WB stage writing register file this cycle
wb_rd  in  REG_W  WB destination
wb_data  in  DATA_W  WB write data
flush  in  1  taken branch resolved; kill decode→EX transfer
ex_hold  in  1  downstream freeze (memory wait)
stall  out  1  hold PC and IF/ID register this cycle
ex_valid  out  1  EX holds a real instruction
ex_aluA  out  DATA_W  operand A to forwarding unit
ex_aluB  out  DATA_W  operand B to forwarding unit
ex_imm  out  DATA_W  registered immediate
ex_rn  out  REG_W  registered rn (forwarding compare)
ex_rm  out  REG_W  registered rm (forwarding compare)
ex_rd  out  REG_W  registered destination
ex_ctrl  out  9  registered control
stall_cnt  out  CNT_W  load-use stall cycles
flush_cnt  out  CNT_W  flush bubbles inserted

Behaviour:
- Reset (reset_n low, asynchronous):
  - ex_valid=0, ex_ctrl=0, ex_aluA/ex_aluB/ex_imm=0.
  - ex_rn/ex_rm/ex_rd=ZERO_REG.
  - Both counters 0.
  - stall=0 while reset asserted.
  - Reset mid-stall drops the stall immediately.
- Bubble: ex_valid=0, ex_ctrl=0, ex_rd=ex_rn=ex_rm=ZERO_REG, data fields=0.
- Load-use detect (combinational; stall is a combinational output with zero-cycle latency). luh=1 when all of:
  - ex_valid, ex_ctrl.memRead, ex_rd!=ZERO_REG, id_valid
  - (ex_rd==id_rn, or (id_uses_rm and ex_rd==id_rm))
- stall = ex_hold | (luh & ~flush).
- Per-edge update, priority order:
  1. flush: load bubble; flush_cnt+1 if id_valid.
  2. ex_hold: retain all registers.
  3. luh: load bubble; stall_cnt+1.
  4. Otherwise load the decode fields: ex_valid←id_valid; ex_ctrl←id_valid?id_ctrl:0.
- Operand capture on a normal load:
  - A ← 0 if id_rn==ZERO_REG.
  - Else A ← wb_data if wb_regWrite & wb_rd==id_rn.
  - Else A ← id_rd1.
  - B uses the same rule with id_rm/id_rd2.
  - WB bypass never triggers for wb_rd==ZERO_REG.
- ex_rd loaded as ZERO_REG when id_ctrl.regWrite=0.
- Single-cycle load-use stall by construction: after the bubble ex_memRead=0, so luh cannot persist. No stall ever exceeds 1 cycle unless ex_hold is asserted.
- Counters saturate at all-ones; no wrap.
- flush and luh together: flush wins; stall=0 from luh (ex_hold can still assert it).
- Latency: decode→EX visible one cycle after the edge.

Test Plan:
1. Reset release, idle id_valid=0 for 3 cycles → ex_valid=0, ex_rd=31, stall=0, counters 0.
2. EX holds LDUR X5 (memRead=1, rd=5); ID has ADD X7,X5,X2 (rn=5) → stall=1 one cycle, next ex_valid=0, stall_cnt=1. Following edge captures ADD, ex_rn=5, stall=0.
3. wb_regWrite=1, wb_rd=3, wb_data=0xDEAD; ID rn=3, id_rd1=0x1111 → ex_aluA=0xDEAD. Same with wb_rd=31 → ex_aluA=0x1111; id_rn=31 → ex_aluA=0.
4. Load-use condition plus flush in the same cycle → stall=0, bubble loaded, flush_cnt=1, stall_cnt=0.
5. ex_hold=1 for 4 cycles with changing ID inputs → ex_* unchanged, stall=1 throughout; release → next ID instruction captured.
6. Force stall_cnt to all-ones (2^CNT_W-1 load-use events) plus one more → stall_cnt stays 0xFFFF.

Source files
------------

// File: rtl/id_ex_stage_reg_if.sv
// Decode-to-EX bundle for the ID/EX pipeline register: decode fields and writeback
// bypass in, registered EX fields, stall request and counters out.
interface id_ex_stage_reg_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned CNT_W  = 16
);
    // Decode side
    logic              id_valid;
    logic [DATA_W-1:0] id_rd1;
    logic [DATA_W-1:0] id_rd2;
    logic [DATA_W-1:0] id_imm;
    logic [REG_W-1:0]  id_rn;
    logic [REG_W-1:0]  id_rm;
    logic [REG_W-1:0]  id_rd;
    logic              id_uses_rm;
    logic [8:0]        id_ctrl;

    // Writeback bypass
    logic              wb_regWrite;
    logic [REG_W-1:0]  wb_rd;
    logic [DATA_W-1:0] wb_data;

    // Pipeline control
    logic              flush;
    logic              ex_hold;
    logic              stall;

    // EX side
    logic              ex_valid;
    logic [DATA_W-1:0] ex_aluA;
    logic [DATA_W-1:0] ex_aluB;
    logic [DATA_W-1:0] ex_imm;
    logic [REG_W-1:0]  ex_rn;
    logic [REG_W-1:0]  ex_rm;
    logic [REG_W-1:0]  ex_rd;
    logic [8:0]        ex_ctrl;

    // Performance counters
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output id_valid, id_rd1, id_rd2, id_imm, id_rn, id_rm, id_rd, id_uses_rm, id_ctrl,
        output wb_regWrite, wb_rd, wb_data, flush, ex_hold,
        input  stall, ex_valid, ex_aluA, ex_aluB, ex_imm, ex_rn, ex_rm, ex_rd, ex_ctrl,
        input  stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rd1, id_rd2, id_imm, id_rn, id_rm, id_rd, id_uses_rm, id_ctrl,
        input  wb_regWrite, wb_rd, wb_data, flush, ex_hold,
        output stall, ex_valid, ex_aluA, ex_aluB, ex_imm, ex_rn, ex_rm, ex_rd, ex_ctrl,
        output stall_cnt, flush_cnt
    );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: load-use hazard detection, WB->ID operand bypass,
// flush/hold handling and saturating stall/flush counters.
module id_ex_stage_reg #(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned REG_W    = 5,
    parameter int unsigned ZERO_REG = 31,
    parameter int unsigned CNT_W    = 16
) (
    input logic              clk,
    input logic              reset_n,
    id_ex_stage_reg_if.slave bus
);
    localparam logic [REG_W-1:0] ZeroReg     = REG_W'(ZERO_REG);
    localparam int unsigned      MemReadBit  = 3;
    localparam int unsigned      RegWriteBit = 1;

    typedef struct packed {
        logic              valid;
        logic [8:0]        ctrl;
        logic [DATA_W-1:0] aluA;
        logic [DATA_W-1:0] aluB;
        logic [DATA_W-1:0] imm;
        logic [REG_W-1:0]  rn;
        logic [REG_W-1:0]  rm;
        logic [REG_W-1:0]  rd;
    } ex_t;

    typedef enum logic [1:0] {ActLoad, ActHold, ActStall, ActFlush} act_e;

    function automatic ex_t bubble();
        ex_t b;
        b       = '0;
        b.rn    = ZeroReg;
        b.rm    = ZeroReg;
        b.rd    = ZeroReg;
        return b;
    endfunction

    // XZR reads as zero; otherwise a same-cycle WB write wins over the stale RF read.
    function automatic logic [DATA_W-1:0] operand(
        input logic [REG_W-1:0]  src,
        input logic [DATA_W-1:0] rfData,
        input logic              wbWe,
        input logic [REG_W-1:0]  wbRd,
        input logic [DATA_W-1:0] wbData
    );
        if (src == ZeroReg) begin
            return '0;
        end else if (wbWe && (wbRd == src)) begin
            return wbData;
        end
        return rfData;
    endfunction

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + CNT_W'(1);
    endfunction

    ex_t              ex_q, ex_d, ex_load;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             luh;
    act_e             act;

    always_comb begin
        luh = ex_q.valid && ex_q.ctrl[MemReadBit] && (ex_q.rd != ZeroReg) && bus.id_valid &&
              ((ex_q.rd == bus.id_rn) || (bus.id_uses_rm && (ex_q.rd == bus.id_rm)));
    end

    always_comb begin
        act = ActLoad;
        if (bus.flush) begin
            act = ActFlush;
        end else if (bus.ex_hold) begin
            act = ActHold;
        end else if (luh) begin
            act = ActStall;
        end
    end

    always_comb begin
        ex_load       = bubble();
        ex_load.valid = bus.id_valid;
        ex_load.ctrl  = bus.id_valid ? bus.id_ctrl : 9'd0;
        ex_load.aluA  = operand(bus.id_rn, bus.id_rd1, bus.wb_regWrite, bus.wb_rd, bus.wb_data);
        ex_load.aluB  = operand(bus.id_rm, bus.id_rd2, bus.wb_regWrite, bus.wb_rd, bus.wb_data);
        ex_load.imm   = bus.id_imm;
        ex_load.rn    = bus.id_rn;
        ex_load.rm    = bus.id_rm;
        // Non-writing instructions carry XZR so forwarding never matches them.
        ex_load.rd    = ex_load.ctrl[RegWriteBit] ? bus.id_rd : ZeroReg;
    end

    always_comb begin
        ex_d        = ex_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        unique case (act)
            ActFlush: begin
                ex_d = bubble();
                if (bus.id_valid) begin
                    flush_cnt_d = satInc(flush_cnt_q);
                end
            end
            ActHold: begin
                ex_d = ex_q;
            end
            ActStall: begin
                ex_d        = bubble();
                stall_cnt_d = satInc(stall_cnt_q);
            end
            ActLoad: begin
                ex_d = ex_load;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_q        <= bubble();
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Gated by reset so an in-flight stall drops the instant reset asserts.
    assign bus.stall     = reset_n & (bus.ex_hold | (luh & ~bus.flush));

    assign bus.ex_valid  = ex_q.valid;
    assign bus.ex_ctrl   = ex_q.ctrl;
    assign bus.ex_aluA   = ex_q.aluA;
    assign bus.ex_aluB   = ex_q.aluB;
    assign bus.ex_imm    = ex_q.imm;
    assign bus.ex_rn     = ex_q.rn;
    assign bus.ex_rm     = ex_q.rm;
    assign bus.ex_rd     = ex_q.rd;
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_id_ex_stage_reg;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned CNT_W  = 8;
    localparam int          CntMax = (1 << CNT_W) - 1;
    localparam logic [4:0]  XZR    = 5'd31;

    localparam logic [8:0] LDUR = 9'b0010_1_1_0_1_1;
    localparam logic [8:0] ADD  = 9'b0010_0_0_0_1_0;
    localparam logic [8:0] STUR = 9'b0010_1_0_1_0_0;

    logic clk;
    logic reset_n;
    bit   cmp_en;
    int   n_checks;
    int   n_pass;

    id_ex_stage_reg_if #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) bus ();

    id_ex_stage_reg #(
        .DATA_W  (DATA_W),
        .REG_W   (REG_W),
        .ZERO_REG(31),
        .CNT_W   (CNT_W)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model of what EX must hold
    logic        m_valid;
    logic [8:0]  m_ctrl;
    logic [63:0] m_a, m_b, m_imm;
    logic [4:0]  m_rn, m_rm, m_rd;
    int          m_stall_cnt, m_flush_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [63:0] src_val(input logic [4:0] r, input logic [63:0] rf);
        if (r == XZR) return 64'd0;
        if (bus.wb_regWrite && bus.wb_rd == r && bus.wb_rd != XZR) return bus.wb_data;
        return rf;
    endfunction

    function automatic bit model_luh();
        if (!(m_valid && m_ctrl[3] && m_rd != XZR && bus.id_valid)) return 1'b0;
        return (m_rd == bus.id_rn) || (bus.id_uses_rm && m_rd == bus.id_rm);
    endfunction

    function automatic logic model_stall();
        return reset_n && (bus.ex_hold || (model_luh() && !bus.flush));
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n || bus.flush || (!bus.ex_hold && model_luh())) begin
            m_valid <= 1'b0; m_ctrl <= '0; m_a <= '0; m_b <= '0; m_imm <= '0;
            m_rn <= XZR; m_rm <= XZR; m_rd <= XZR;
            if (!reset_n) begin
                m_stall_cnt <= 0;
                m_flush_cnt <= 0;
            end else if (bus.flush) begin
                if (bus.id_valid && m_flush_cnt < CntMax) m_flush_cnt <= m_flush_cnt + 1;
            end else if (m_stall_cnt < CntMax) begin
                m_stall_cnt <= m_stall_cnt + 1;
            end
        end else if (!bus.ex_hold) begin
            m_valid <= bus.id_valid;
            m_ctrl  <= bus.id_valid ? bus.id_ctrl : 9'd0;
            m_a     <= src_val(bus.id_rn, bus.id_rd1);
            m_b     <= src_val(bus.id_rm, bus.id_rd2);
            m_imm   <= bus.id_imm;
            m_rn    <= bus.id_rn;
            m_rm    <= bus.id_rm;
            m_rd    <= (bus.id_valid && bus.id_ctrl[1]) ? bus.id_rd : XZR;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_stall", {63'd0, bus.stall}, {63'd0, model_stall()});
            chk("m_ex_valid", {63'd0, bus.ex_valid}, {63'd0, m_valid});
            chk("m_ex_ctrl", {55'd0, bus.ex_ctrl}, {55'd0, m_ctrl});
            chk("m_ex_aluA", bus.ex_aluA, m_a);
            chk("m_ex_aluB", bus.ex_aluB, m_b);
            chk("m_ex_imm", bus.ex_imm, m_imm);
            chk("m_ex_regs", {49'd0, bus.ex_rn, bus.ex_rm, bus.ex_rd}, {49'd0, m_rn, m_rm, m_rd});
            chk("m_stall_cnt", {56'd0, bus.stall_cnt}, 64'(m_stall_cnt));
            chk("m_flush_cnt", {56'd0, bus.flush_cnt}, 64'(m_flush_cnt));
        end
    end

    task automatic set_id(input logic v, input logic [4:0] rn, input logic [4:0] rm,
                          input logic [4:0] rd, input logic um, input logic [8:0] ctrl,
                          input logic [63:0] rd1, input logic [63:0] rd2, input logic [63:0] imm);
        bus.id_valid = v; bus.id_rn = rn; bus.id_rm = rm; bus.id_rd = rd;
        bus.id_uses_rm = um; bus.id_ctrl = ctrl;
        bus.id_rd1 = rd1; bus.id_rd2 = rd2; bus.id_imm = imm;
    endtask

    task automatic idle();
        set_id(1'b0, XZR, XZR, XZR, 1'b0, 9'd0, 64'd0, 64'd0, 64'd0);
        bus.wb_regWrite = 1'b0; bus.wb_rd = XZR; bus.wb_data = 64'd0;
        bus.flush = 1'b0; bus.ex_hold = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0; n_pass = 0; cmp_en = 1'b0;
        idle();
        reset_n = 1'b0;
        bus.ex_hold = 1'b1;
        #2 chk("stall_in_reset", {63'd0, bus.stall}, 64'd0);
        bus.ex_hold = 1'b0;
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;
        cmp_en = 1'b1;

        // Idle after reset
        repeat (3) tick();
        chk("idle_ex_valid", {63'd0, bus.ex_valid}, 64'd0);
        chk("idle_ex_rd", {59'd0, bus.ex_rd}, 64'd31);
        chk("idle_stall", {63'd0, bus.stall}, 64'd0);
        chk("idle_cnts", {48'd0, bus.stall_cnt, bus.flush_cnt}, 64'd0);

        // Load-use: LDUR X5 then ADD X7,X5,X2
        set_id(1'b1, 5'd1, XZR, 5'd5, 1'b0, LDUR, 64'h10, 64'd0, 64'h8);
        tick();
        chk("ldur_ex_rd", {59'd0, bus.ex_rd}, 64'd5);
        set_id(1'b1, 5'd5, 5'd2, 5'd7, 1'b1, ADD, 64'h1, 64'h2, 64'd0);
        #1 chk("luh_stall", {63'd0, bus.stall}, 64'd1);
        tick();
        chk("luh_bubble_valid", {63'd0, bus.ex_valid}, 64'd0);
        chk("luh_stall_cnt", {56'd0, bus.stall_cnt}, 64'd1);
        chk("model_stall_cnt", 64'(m_stall_cnt), 64'd1);
        #1 chk("luh_stall_clear", {63'd0, bus.stall}, 64'd0);
        tick();
        chk("add_captured", {58'd0, bus.ex_valid, bus.ex_rn}, {58'd0, 1'b1, 5'd5});
        chk("add_ex_rd", {59'd0, bus.ex_rd}, 64'd7);

        // WB bypass
        bus.wb_regWrite = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 64'hDEAD;
        set_id(1'b1, 5'd3, 5'd3, 5'd9, 1'b1, ADD, 64'h1111, 64'h2222, 64'd0);
        tick();
        chk("wb_bypass_a", bus.ex_aluA, 64'hDEAD);
        chk("wb_bypass_b", bus.ex_aluB, 64'hDEAD);
        bus.wb_rd = XZR;
        tick();
        chk("wb_xzr_a", bus.ex_aluA, 64'h1111);
        chk("wb_xzr_b", bus.ex_aluB, 64'h2222);
        set_id(1'b1, XZR, 5'd3, 5'd4, 1'b1, STUR, 64'h1111, 64'h2222, 64'd0);
        tick();
        chk("rn_xzr_a", bus.ex_aluA, 64'd0);
        chk("nowrite_rd", {59'd0, bus.ex_rd}, 64'd31);
        bus.wb_regWrite = 1'b0;

        // Reset asserted mid-stall
        set_id(1'b1, 5'd1, XZR, 5'd5, 1'b0, LDUR, 64'h10, 64'd0, 64'h8);
        tick();
        set_id(1'b1, 5'd5, 5'd2, 5'd7, 1'b1, ADD, 64'h1, 64'h2, 64'd0);
        #1 chk("pre_reset_stall", {63'd0, bus.stall}, 64'd1);
        reset_n = 1'b0;
        #1 chk("reset_drops_stall", {63'd0, bus.stall}, 64'd0);
        chk("reset_clears", {55'd0, bus.ex_valid, bus.stall_cnt}, 64'd0);
        @(negedge clk);
        #1 reset_n = 1'b1;

        // Flush wins over load-use
        set_id(1'b1, 5'd1, XZR, 5'd5, 1'b0, LDUR, 64'h10, 64'd0, 64'h8);
        tick();
        set_id(1'b1, 5'd5, 5'd2, 5'd7, 1'b1, ADD, 64'h1, 64'h2, 64'd0);
        bus.flush = 1'b1;
        #1 chk("flush_luh_stall", {63'd0, bus.stall}, 64'd0);
        tick();
        bus.flush = 1'b0;
        chk("flush_bubble", {58'd0, bus.ex_valid, bus.ex_rd}, {58'd0, 1'b0, 5'd31});
        chk("flush_cnt", {56'd0, bus.flush_cnt}, 64'd1);
        chk("flush_stall_cnt", {56'd0, bus.stall_cnt}, 64'd0);
        chk("model_flush_cnt", 64'(m_flush_cnt), 64'd1);

        // Downstream hold
        set_id(1'b1, 5'd2, 5'd3, 5'd6, 1'b1, ADD, 64'hAAAA, 64'hBBBB, 64'hCCCC);
        tick();
        bus.ex_hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_id(1'b1, 5'(i), 5'(i + 1), 5'(10 + i), 1'b1, ADD,
                   {$urandom, $urandom}, {$urandom, $urandom}, 64'(i));
            #1 chk("hold_stall", {63'd0, bus.stall}, 64'd1);
            tick();
            chk("hold_ex", {bus.ex_aluA[15:0], bus.ex_imm[15:0], 27'd0, bus.ex_rd},
                {16'hAAAA, 16'hCCCC, 27'd0, 5'd6});
        end
        bus.ex_hold = 1'b0;
        set_id(1'b1, 5'd4, 5'd5, 5'd20, 1'b1, ADD, 64'd0, 64'd0, 64'h1234);
        tick();
        chk("hold_release", {bus.ex_imm[15:0], 43'd0, bus.ex_rd}, {16'h1234, 43'd0, 5'd20});

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            set_id(1'(($urandom & 7) != 0),
                   ($urandom_range(0, 7) == 0) ? XZR : 5'($urandom_range(0, 7)),
                   ($urandom_range(0, 7) == 0) ? XZR : 5'($urandom_range(0, 7)),
                   ($urandom_range(0, 7) == 0) ? XZR : 5'($urandom_range(0, 7)),
                   1'($urandom), 9'($urandom),
                   {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
            bus.wb_regWrite = 1'($urandom);
            bus.wb_rd       = ($urandom_range(0, 7) == 0) ? XZR : 5'($urandom_range(0, 7));
            bus.wb_data     = {$urandom, $urandom};
            bus.flush       = ($urandom_range(0, 9) == 0);
            bus.ex_hold     = ($urandom_range(0, 9) == 0);
            tick();
        end

        // Saturate the stall counter
        idle();
        tick();
        for (int i = 0; i < CntMax + 5; i++) begin
            set_id(1'b1, 5'd1, XZR, 5'd5, 1'b0, LDUR, 64'h10, 64'd0, 64'h8);
            tick();
            set_id(1'b1, 5'd5, 5'd2, 5'd7, 1'b1, ADD, 64'h1, 64'h2, 64'd0);
            tick();
        end
        chk("stall_cnt_sat", {56'd0, bus.stall_cnt}, 64'(CntMax));
        chk("model_stall_sat", 64'(m_stall_cnt), 64'(CntMax));

        idle();
        tick();
        @(negedge clk);
        #1 cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
